// File: rtl/proc_pkg.sv
// Shared opcodes, FSM states and default widths
// for the 8-bit processor control path.
package proc_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: return-address LIFO for pc_sequencer.
// Only built when PC_SEQ_CALL_STACK_EN is defined.
`ifdef PC_SEQ_CALL_STACK_EN
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign top   = mem[AW'(cnt - CW'(1))];

  // Occupancy count; push and pop are never issued together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[cnt[AW-1:0]] <= din;
    end
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator with halt FSM and
// optional return stack (PC_SEQ_CALL_STACK_EN).
module pc_sequencer
  import proc_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STACK_DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] PCOut,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Target,
  input  logic             Zero,
  input  logic             Stall,
  input  logic             Resume,
  output logic [WIDTH-1:0] PCIn,
  output logic             PCWrite,
  output logic             Halted,
  output logic [1:0]       StackErr
);

  state_e           st;
  logic [WIDTH-1:0] pcin;
  logic             we;
  logic             halted;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] nxt;
  logic             acc;

  assign acc = (st == ST_RUN) && !Stall;

`ifdef PC_SEQ_CALL_STACK_EN
  logic             push_req;
  logic             pop_req;
  logic             ovf;
  logic             udf;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] top;
  logic [1:0]       serr;

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (Clock),
    .rst_n (Resetn),
    .push  (acc && push_req),
    .pop   (acc && pop_req),
    .din   (inc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      serr <= '0;
    end else if (acc) begin
      serr <= serr | {udf, ovf};
    end
  end

  assign StackErr = serr;
`else
  logic unused_depth;
  assign unused_depth = ^STACK_DEPTH;
  assign StackErr     = 2'b00;
`endif

  // Next-PC mux and stack requests decoded from Op.
  always_comb begin
    inc = PCOut + WIDTH'(1);
    nxt = inc;
`ifdef PC_SEQ_CALL_STACK_EN
    push_req = 1'b0;
    pop_req  = 1'b0;
    ovf      = 1'b0;
    udf      = 1'b0;
`endif
    unique case (1'b1)
      (Op == OP_JMP): nxt = Target;
      (Op == OP_BRZ): nxt = Zero ? Target : inc;
      (Op == OP_CALL): begin
        nxt = Target;
`ifdef PC_SEQ_CALL_STACK_EN
        push_req = !full;
        ovf      = full;
`endif
      end
      (Op == OP_RET): begin
`ifdef PC_SEQ_CALL_STACK_EN
        if (empty) begin
          udf = 1'b1;
        end else begin
          pop_req = 1'b1;
          nxt     = top;
        end
`endif
      end
      default: ;
    endcase
  end

  // RUN/HALTED FSM with registered PCIn/PCWrite/Halted.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st     <= ST_RUN;
      pcin   <= '0;
      we     <= 1'b0;
      halted <= 1'b0;
    end else if (Stall) begin
      we <= 1'b0;
    end else begin
      unique case (st)
        ST_RUN: begin
          if (Op == OP_HALT) begin
            st     <= ST_HALTED;
            halted <= 1'b1;
            we     <= 1'b0;
          end else begin
            pcin <= nxt;
            we   <= 1'b1;
          end
        end
        ST_HALTED: begin
          we <= 1'b0;
          if (Resume) begin
            st     <= ST_RUN;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

  assign PCIn    = pcin;
  assign PCWrite = we;
  assign Halted  = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer;
// expectations follow PC_SEQ_CALL_STACK_EN.
module tb_pc_sequencer;
  import proc_pkg::*;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       Clock;
  logic       Resetn;
  logic [7:0] PCOut;
  logic [2:0] Op;
  logic [7:0] Target;
  logic       Zero;
  logic       Stall;
  logic       Resume;
  logic [7:0] PCIn;
  logic       PCWrite;
  logic       Halted;
  logic [1:0] StackErr;

  pc_sequencer #(
    .WIDTH       (8),
    .STACK_DEPTH (4)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .PCOut    (PCOut),
    .Op       (Op),
    .Target   (Target),
    .Zero     (Zero),
    .Stall    (Stall),
    .Resume   (Resume),
    .PCIn     (PCIn),
    .PCWrite  (PCWrite),
    .Halted   (Halted),
    .StackErr (StackErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] tgt;
    logic       z;
    logic       st;
    logic       rs;
    logic [7:0] pco;
    logic [7:0] epc;
    logic       ewe;
    logic       eh;
    logic [1:0] ese;
  } step_t;

  logic [11:0] sbq[$];
  logic [11:0] got;
  logic [11:0] ex;
  int          n_checks = 0;
  int          n_fail   = 0;
  step_t       s[$];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input step_t t);
    Op     = t.op;
    Target = t.tgt;
    Zero   = t.z;
    Stall  = t.st;
    Resume = t.rs;
    PCOut  = t.pco;
    sbq.push_back({t.epc, t.ewe, t.eh, t.ese});
    tick();
  endtask

  task automatic idle_inputs();
    Op     = OP_SEQ;
    Target = 8'h00;
    Zero   = 1'b0;
    Stall  = 1'b0;
    Resume = 1'b0;
    PCOut  = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Resetn = 1'b1;
    tick();
    tick();
    #2;
    Resetn = 1'b0;
    sbq.push_back(12'h000);
    #1;
    got = {PCIn, PCWrite, Halted, StackErr};
    ex  = sbq.pop_front();
    n_checks++;
    if (got !== ex)
      $display("FAIL reset: got %h, exp %h", got, ex);
    if (got !== ex) n_fail++;
    tick();
    Resetn = 1'b1;
  endtask

  task automatic test_seq();
    logic [7:0] pc;
    step_t t;
    do_reset();
    pc = 8'h00;
    for (int i = 0; i < 300; i++) begin
      t = step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b0,
                  pc, pc + 8'h01, 1'b1, 1'b0, 2'b00};
      drive(t);
      got = {PCIn, PCWrite, Halted, StackErr};
      ex  = sbq.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL seq[%0d]: got %h, exp %h", i, got, ex);
      end
      pc = ex[11:4];
    end
  endtask

  task automatic test_branch();
    do_reset();
    s.delete();
    s.push_back(step_t'{OP_BRZ, 8'h40, 1'b1, 1'b0, 1'b0,
                        8'h10, 8'h40, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_BRZ, 8'h40, 1'b0, 1'b0, 1'b0,
                        8'h10, 8'h11, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_JMP, 8'h33, 1'b0, 1'b0, 1'b0,
                        8'h10, 8'h33, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{3'd6, 8'h99, 1'b1, 1'b0, 1'b0,
                        8'h33, 8'h34, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{3'd7, 8'h99, 1'b1, 1'b0, 1'b0,
                        8'hFF, 8'h00, 1'b1, 1'b0, 2'b00});
    foreach (s[i]) begin
      drive(s[i]);
      got = {PCIn, PCWrite, Halted, StackErr};
      ex  = sbq.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h, exp %h", i, got, ex);
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    s.delete();
    s.push_back(step_t'{OP_CALL, 8'h80, 1'b0, 1'b0, 1'b0,
                        8'h05, 8'h80, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h85, STK ? 8'h06 : 8'h86,
                        1'b1, 1'b0, 2'b00});
    for (int k = 1; k <= 4; k++)
      s.push_back(step_t'{OP_CALL, 8'(8'h10 * (k + 1)),
                          1'b0, 1'b0, 1'b0,
                          8'(8'h10 * k), 8'(8'h10 * (k + 1)),
                          1'b1, 1'b0, 2'b00});
    for (int k = 4; k >= 1; k--)
      s.push_back(step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                          8'h60,
                          STK ? 8'(8'h10 * k + 1) : 8'h61,
                          1'b1, 1'b0, 2'b00});
    foreach (s[i]) begin
      drive(s[i]);
      got = {PCIn, PCWrite, Halted, StackErr};
      ex  = sbq.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL callret[%0d]: got %h, exp %h", i, got, ex);
      end
    end
  endtask

  task automatic test_stack_err();
    do_reset();
    s.delete();
    for (int k = 1; k <= 5; k++)
      s.push_back(step_t'{OP_CALL, 8'(8'hA0 + k),
                          1'b0, 1'b0, 1'b0,
                          8'(k), 8'(8'hA0 + k), 1'b1, 1'b0,
                          (STK && k == 5) ? 2'b01 : 2'b00});
    for (int k = 5; k >= 2; k--)
      s.push_back(step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                          8'hF0, STK ? 8'(k) : 8'hF1,
                          1'b1, 1'b0, STK ? 2'b01 : 2'b00});
    s.push_back(step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'hF0, 8'hF1, 1'b1, 1'b0,
                        STK ? 2'b11 : 2'b00});
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'hF1, 8'hF2, 1'b1, 1'b0,
                        STK ? 2'b11 : 2'b00});
    foreach (s[i]) begin
      drive(s[i]);
      got = {PCIn, PCWrite, Halted, StackErr};
      ex  = sbq.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL stackerr[%0d]: got %h, exp %h", i, got, ex);
      end
    end
  endtask

  task automatic test_halt_stall();
    do_reset();
    s.delete();
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h20, 8'h21, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_HALT, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h21, 8'h21, 1'b0, 1'b1, 2'b00});
    for (int k = 0; k < 3; k++)
      s.push_back(step_t'{OP_JMP, 8'h99, 1'b0, 1'b0, 1'b0,
                          8'h21, 8'h21, 1'b0, 1'b1, 2'b00});
    s.push_back(step_t'{OP_JMP, 8'h99, 1'b0, 1'b0, 1'b1,
                        8'h21, 8'h21, 1'b0, 1'b0, 2'b00});
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h21, 8'h22, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_JMP, 8'h99, 1'b0, 1'b1, 1'b0,
                        8'h22, 8'h22, 1'b0, 1'b0, 2'b00});
    s.push_back(step_t'{OP_JMP, 8'h77, 1'b0, 1'b0, 1'b0,
                        8'h22, 8'h77, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_HALT, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h77, 8'h77, 1'b0, 1'b1, 2'b00});
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b1, 1'b1,
                        8'h77, 8'h77, 1'b0, 1'b1, 2'b00});
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b1,
                        8'h77, 8'h77, 1'b0, 1'b0, 2'b00});
    s.push_back(step_t'{OP_SEQ, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h77, 8'h78, 1'b1, 1'b0, 2'b00});
    s.push_back(step_t'{OP_CALL, 8'h40, 1'b0, 1'b1, 1'b0,
                        8'h78, 8'h78, 1'b0, 1'b0, 2'b00});
    s.push_back(step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                        8'h78, 8'h79, 1'b1, 1'b0,
                        STK ? 2'b10 : 2'b00});
    foreach (s[i]) begin
      drive(s[i]);
      got = {PCIn, PCWrite, Halted, StackErr};
      ex  = sbq.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %h, exp %h", i, got, ex);
      end
    end
  endtask

  task automatic test_reset_mid_call();
    step_t t;
    do_reset();
    t = step_t'{OP_CALL, 8'h80, 1'b0, 1'b0, 1'b0,
                8'h05, 8'h80, 1'b1, 1'b0, 2'b00};
    drive(t);
    got = {PCIn, PCWrite, Halted, StackErr};
    ex  = sbq.pop_front();
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL midrst call: got %h, exp %h", got, ex);
    end
    Op     = OP_CALL;
    Target = 8'h90;
    PCOut  = 8'h80;
    #3;
    Resetn = 1'b0;
    sbq.push_back(12'h000);
    #1;
    got = {PCIn, PCWrite, Halted, StackErr};
    ex  = sbq.pop_front();
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL midrst async: got %h, exp %h", got, ex);
    end
    tick();
    Resetn = 1'b1;
    t = step_t'{OP_RET, 8'h00, 1'b0, 1'b0, 1'b0,
                8'h30, 8'h31, 1'b1, 1'b0,
                STK ? 2'b10 : 2'b00};
    drive(t);
    got = {PCIn, PCWrite, Halted, StackErr};
    ex  = sbq.pop_front();
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL midrst ret: got %h, exp %h", got, ex);
    end
  endtask

  initial begin
    Resetn = 1'b1;
    idle_inputs();
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_stack_err();
    test_halt_stall();
    test_reset_mid_call();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
